// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry record for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned ROB_IDX_W  = 4;
    localparam int unsigned PREG_WIDTH = 6;
    localparam int unsigned AREG_WIDTH = 5;
    localparam int unsigned PC_WIDTH   = 12;

    // One ROB entry's payload; valid/done live in separate flag vectors.
    typedef struct packed {
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] ard;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] old_prd;
        logic [PC_WIDTH-1:0]   pc;
        logic                  is_store;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, marks completion from two writeback
// ports, and retires at most one done entry per cycle from head.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_ard,
    input  logic [PREG_WIDTH-1:0] alloc_prd,
    input  logic [PREG_WIDTH-1:0] alloc_old_prd,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    input  logic                  alloc_is_store,
    output logic [ROB_IDX_W-1:0]  alloc_idx,

    input  logic                  cmp0_valid,
    input  logic [ROB_IDX_W-1:0]  cmp0_idx,
    input  logic                  cmp1_valid,
    input  logic [ROB_IDX_W-1:0]  cmp1_idx,

    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_ard,
    output logic [PREG_WIDTH-1:0] retire_prd,
    output logic [PC_WIDTH-1:0]   retire_pc,
    output logic                  rob_push,
    output logic [PREG_WIDTH-1:0] rob_free_reg,
    output logic                  store_commit,

    output logic [ROB_IDX_W:0]    count,
    output logic                  empty,
    output logic                  full
);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [ROB_IDX_W:0]    head_q, tail_q;
    logic [ROB_IDX_W-1:0]  head_idx, tail_idx;
    logic [ROB_DEPTH-1:0]  valid_q, done_q;

    // Flat per-field payload storage.
    logic                  reg_write_q [ROB_DEPTH];
    logic [AREG_WIDTH-1:0] ard_q       [ROB_DEPTH];
    logic [PREG_WIDTH-1:0] prd_q       [ROB_DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_q   [ROB_DEPTH];
    logic [PC_WIDTH-1:0]   pc_q        [ROB_DEPTH];
    logic                  is_store_q  [ROB_DEPTH];

    rob_entry_t head_entry;
    logic       do_alloc;
    logic       do_retire;

    assign head_idx    = head_q[ROB_IDX_W-1:0];
    assign tail_idx    = tail_q[ROB_IDX_W-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[ROB_IDX_W] != tail_q[ROB_IDX_W]);
    assign empty       = (head_q == tail_q);
    assign count       = tail_q - head_q;
    assign alloc_ready = !full;
    assign alloc_idx   = tail_idx;

    // full is judged before this cycle's retire, so a slot freed now is reused next cycle.
    assign do_alloc  = alloc_valid && !full;
    assign do_retire = valid_q[head_idx] && done_q[head_idx];

    // Gather the head entry's payload for the retire registers.
    always_comb begin
        head_entry           = '0;
        head_entry.reg_write = reg_write_q[head_idx];
        head_entry.ard       = ard_q[head_idx];
        head_entry.prd       = prd_q[head_idx];
        head_entry.old_prd   = old_prd_q[head_idx];
        head_entry.pc        = pc_q[head_idx];
        head_entry.is_store  = is_store_q[head_idx];
    end

    // Head/tail pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (do_alloc)  tail_q <= tail_q + 1'b1;
            if (do_retire) head_q <= head_q + 1'b1;
        end
    end

    // Entry valid/done flags; completions on invalid entries are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (do_retire) valid_q[head_idx] <= 1'b0;
            if (cmp0_valid && valid_q[cmp0_idx]) done_q[cmp0_idx] <= 1'b1;
            if (cmp1_valid && valid_q[cmp1_idx]) done_q[cmp1_idx] <= 1'b1;
            // Alloc never targets head while retiring (that would need full), so no clash.
            if (do_alloc) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
            end
        end
    end

    // Payload write on allocation; contents are meaningless while the entry is invalid.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            reg_write_q[tail_idx] <= alloc_reg_write;
            ard_q[tail_idx]       <= alloc_ard;
            prd_q[tail_idx]       <= alloc_prd;
            old_prd_q[tail_idx]   <= alloc_old_prd;
            pc_q[tail_idx]        <= alloc_pc;
            is_store_q[tail_idx]  <= alloc_is_store;
        end
    end

    // Registered retire outputs: strobes pulse for one cycle, data holds between retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid <= 1'b0;
            rob_push     <= 1'b0;
            store_commit <= 1'b0;
            retire_ard   <= '0;
            retire_prd   <= '0;
            retire_pc    <= '0;
            rob_free_reg <= '0;
        end else begin
            retire_valid <= do_retire;
            rob_push     <= do_retire && head_entry.reg_write;
            store_commit <= do_retire && head_entry.is_store;
            if (do_retire) begin
                retire_ard   <= head_entry.ard;
                retire_prd   <= head_entry.prd;
                retire_pc    <= head_entry.pc;
                rob_free_reg <= head_entry.old_prd;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic                  alloc_reg_write;
    logic [AREG_WIDTH-1:0] alloc_ard;
    logic [PREG_WIDTH-1:0] alloc_prd;
    logic [PREG_WIDTH-1:0] alloc_old_prd;
    logic [PC_WIDTH-1:0]   alloc_pc;
    logic                  alloc_is_store;
    logic [ROB_IDX_W-1:0]  alloc_idx;
    logic                  cmp0_valid, cmp1_valid;
    logic [ROB_IDX_W-1:0]  cmp0_idx, cmp1_idx;
    logic                  retire_valid;
    logic [AREG_WIDTH-1:0] retire_ard;
    logic [PREG_WIDTH-1:0] retire_prd;
    logic [PC_WIDTH-1:0]   retire_pc;
    logic                  rob_push;
    logic [PREG_WIDTH-1:0] rob_free_reg;
    logic                  store_commit;
    logic [ROB_IDX_W:0]    count;
    logic                  empty, full;

    int errors = 0;
    int checks = 0;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_reg_write(alloc_reg_write),
        .alloc_ard      (alloc_ard),
        .alloc_prd      (alloc_prd),
        .alloc_old_prd  (alloc_old_prd),
        .alloc_pc       (alloc_pc),
        .alloc_is_store (alloc_is_store),
        .alloc_idx      (alloc_idx),
        .cmp0_valid     (cmp0_valid),
        .cmp0_idx       (cmp0_idx),
        .cmp1_valid     (cmp1_valid),
        .cmp1_idx       (cmp1_idx),
        .retire_valid   (retire_valid),
        .retire_ard     (retire_ard),
        .retire_prd     (retire_prd),
        .retire_pc      (retire_pc),
        .rob_push       (rob_push),
        .rob_free_reg   (rob_free_reg),
        .store_commit   (store_commit),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int ret_cnt;
        rst             = 1'b1;
        alloc_valid     = 1'b0;
        alloc_reg_write = 1'b0;
        alloc_ard       = '0;
        alloc_prd       = '0;
        alloc_old_prd   = '0;
        alloc_pc        = '0;
        alloc_is_store  = 1'b0;
        cmp0_valid      = 1'b0;
        cmp0_idx        = '0;
        cmp1_valid      = 1'b0;
        cmp1_idx        = '0;
        step();
        step();
        rst = 1'b0;

        // 1. Reset state
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(alloc_ready), 1);
        check("rst_idx", 32'(alloc_idx), 0);
        check("rst_rv", 32'(retire_valid), 0);
        check("rst_push", 32'(rob_push), 0);
        step();
        check("idle_rv", 32'(retire_valid), 0);

        // 2. Out-of-order completion
        alloc_valid     = 1'b1;
        alloc_reg_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_ard     = AREG_WIDTH'(i + 5);
            alloc_prd     = PREG_WIDTH'(33 + i);
            alloc_old_prd = PREG_WIDTH'(1 + i);
            alloc_pc      = PC_WIDTH'(16 + i);
            step();
        end
        alloc_valid = 1'b0;
        check("ooo_count", 32'(count), 3);
        cmp0_valid = 1'b1; cmp0_idx = 4'd1;
        step();
        cmp0_valid = 1'b0;
        check("ooo_norv1", 32'(retire_valid), 0);
        cmp1_valid = 1'b1; cmp1_idx = 4'd2;
        step();
        cmp1_valid = 1'b0;
        check("ooo_norv2", 32'(retire_valid), 0);
        cmp0_valid = 1'b1; cmp0_idx = 4'd0;
        step();
        cmp0_valid = 1'b0;
        check("ooo_norv3", 32'(retire_valid), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ooo_rv", 32'(retire_valid), 1);
            check("ooo_push", 32'(rob_push), 1);
            check("ooo_free", 32'(rob_free_reg), 32'(1 + i));
            check("ooo_prd", 32'(retire_prd), 32'(33 + i));
            check("ooo_ard", 32'(retire_ard), 32'(5 + i));
        end
        step();
        check("ooo_done_rv", 32'(retire_valid), 0);
        check("ooo_done_push", 32'(rob_push), 0);
        check("ooo_empty", 32'(empty), 1);
        check("ooo_hold_prd", 32'(retire_prd), 35);

        // 3. Full
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_pc = PC_WIDTH'(i);
            step();
        end
        check("full_full", 32'(full), 1);
        check("full_ready", 32'(alloc_ready), 0);
        check("full_count", 32'(count), 16);
        alloc_pc = 12'hFFF;
        step();
        alloc_valid = 1'b0;
        check("full_17_idx", 32'(alloc_idx), 0);
        check("full_17_count", 32'(count), 16);
        check("full_17_full", 32'(full), 1);
        cmp0_valid = 1'b1; cmp0_idx = 4'd0;
        step();
        cmp0_valid = 1'b0;
        check("full_still", 32'(full), 1);
        step();
        check("full_rv", 32'(retire_valid), 1);
        check("full_rpc", 32'(retire_pc), 0);
        check("full_cleared", 32'(full), 0);
        check("full_ready2", 32'(alloc_ready), 1);
        check("full_count2", 32'(count), 15);

        // 4. Wrap-around with overlapping alloc/complete/retire
        do_reset();
        ret_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = PC_WIDTH'(100 + i);
            cmp0_valid  = (i > 0);
            cmp0_idx    = ROB_IDX_W'(i - 1);
            check("wrap_idx", 32'(alloc_idx), 32'(i % 16));
            step();
            if (retire_valid) begin
                check("wrap_rpc", 32'(retire_pc), 32'(100 + ret_cnt));
                ret_cnt++;
            end
            check("wrap_cnt_le16", 32'(count <= 5'd16), 1);
        end
        alloc_valid = 1'b0;
        cmp0_valid  = 1'b1;
        cmp0_idx    = 4'd7;
        for (int i = 0; i < 6; i++) begin
            step();
            cmp0_valid = 1'b0;
            if (retire_valid) begin
                check("wrap_rpc", 32'(retire_pc), 32'(100 + ret_cnt));
                ret_cnt++;
            end
        end
        check("wrap_total", 32'(ret_cnt), 40);
        check("wrap_empty", 32'(empty), 1);

        // 5. Store retire
        check("st_idx", 32'(alloc_idx), 8);
        alloc_valid     = 1'b1;
        alloc_reg_write = 1'b0;
        alloc_is_store  = 1'b1;
        alloc_pc        = 12'h0A4;
        alloc_old_prd   = 6'd9;
        step();
        alloc_valid    = 1'b0;
        alloc_is_store = 1'b0;
        cmp1_valid = 1'b1; cmp1_idx = 4'd8;
        step();
        cmp1_valid = 1'b0;
        check("st_norv", 32'(retire_valid), 0);
        step();
        check("st_rv", 32'(retire_valid), 1);
        check("st_commit", 32'(store_commit), 1);
        check("st_push", 32'(rob_push), 0);
        check("st_pc", 32'(retire_pc), 32'h0A4);
        step();
        check("st_commit_pulse", 32'(store_commit), 0);

        // 6. Reset mid-operation
        do_reset();
        alloc_valid     = 1'b1;
        alloc_reg_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_pc = PC_WIDTH'(200 + i);
            step();
        end
        alloc_valid = 1'b0;
        cmp0_valid = 1'b1; cmp0_idx = 4'd0;
        cmp1_valid = 1'b1; cmp1_idx = 4'd1;
        step();
        cmp0_valid = 1'b0;
        cmp1_valid = 1'b0;
        check("mr_pre_count", 32'(count), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_rv", 32'(retire_valid), 0);
        check("mr_push", 32'(rob_push), 0);
        check("mr_count", 32'(count), 0);
        check("mr_empty", 32'(empty), 1);
        check("mr_idx", 32'(alloc_idx), 0);
        check("mr_rpc", 32'(retire_pc), 0);
        step();
        check("mr_rv2", 32'(retire_valid), 0);
        check("mr_push2", 32'(rob_push), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
